// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit ALU arbiter: FSM state encoding and opcodes.
package alu4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_OR_A   = 4'd0;
  localparam logic [3:0] OP_XOR_A  = 4'd1;
  localparam logic [3:0] OP_AND_A  = 4'd2;
  localparam logic [3:0] OP_ZERO_A = 4'd3;
  localparam logic [3:0] OP_NOT_A  = 4'd4;
  localparam logic [3:0] OP_ZERO_B = 4'd5;
  localparam logic [3:0] OP_NOT_B  = 4'd6;
  localparam logic [3:0] OP_AND_B  = 4'd7;
  localparam logic [3:0] OP_AND    = 4'd8;
  localparam logic [3:0] OP_OR     = 4'd9;
  localparam logic [3:0] OP_XOR    = 4'd10;
  localparam logic [3:0] OP_GT     = 4'd11;
  localparam logic [3:0] OP_LT     = 4'd12;
  localparam logic [3:0] OP_EQ     = 4'd13;
  localparam logic [3:0] OP_ADD    = 4'd14;
  localparam logic [3:0] OP_SUB    = 4'd15;

endpackage

// File: rtl/alu4_core.sv
// Purely combinational 4-bit ALU: x is the low result nibble, y the high nibble.
module alu4_core
  import alu4_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] op,
  output logic [3:0] x,
  output logic [3:0] y
);

  logic [7:0] res;

  // Single-bit results sit in res[0]; the rest of res stays zero.
  always_comb begin
    res = 8'h00;
    case (op)
      OP_OR_A:   res = {7'b0, |a};
      OP_XOR_A:  res = {7'b0, ^a};
      OP_AND_A:  res = {7'b0, &a};
      OP_ZERO_A: res = {7'b0, a == 4'h0};
      OP_NOT_A:  res = {4'h0, ~a};
      OP_ZERO_B: res = {7'b0, b == 4'h0};
      OP_NOT_B:  res = {4'h0, ~b};
      OP_AND_B:  res = {7'b0, &b};
      OP_AND:    res = {4'h0, a & b};
      OP_OR:     res = {4'h0, a | b};
      OP_XOR:    res = {4'h0, a ^ b};
      OP_GT:     res = {7'b0, a > b};
      OP_LT:     res = {7'b0, a < b};
      OP_EQ:     res = {7'b0, a == b};
      OP_ADD:    res = {4'h0, a} + {4'h0, b};
      OP_SUB:    res = {4'h0, a} - {4'h0, b};
      default:   res = 8'h00;
    endcase
  end

  assign x = res[3:0];
  assign y = res[7:4];

endmodule

// File: rtl/alu4_arbiter.sv
// Two requesters share one ALU through a round-robin arbiter and an IDLE/EXEC/RESP FSM.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid and payload hold until then.
module alu4_arbiter
  import alu4_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [3:0]       rsp_x,
  output logic [3:0]       rsp_y,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output state_t           dbg_state
);

  state_t     state, state_nxt;
  logic       rr_ptr;
  logic       grant0, grant1;
  logic [3:0] lat_a, lat_b, lat_op;
  logic       lat_id;
  logic [3:0] alu_x, alu_y;

  // rr_ptr == 1 means req1 wins a tie.
  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req0_valid && (!req1_valid || !rr_ptr)) grant0 = 1'b1;
        else if (req1_valid)                        grant1 = 1'b1;
        if (grant0 || grant1) state_nxt = ST_EXEC;
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= 1'b0;
      lat_a    <= 4'h0;
      lat_b    <= 4'h0;
      lat_op   <= 4'h0;
      lat_id   <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_x    <= 4'h0;
      rsp_y    <= 4'h0;
      op_count <= '0;
    end else begin
      state <= state_nxt;
      if (grant0 || grant1) begin
        lat_a  <= grant1 ? req1_a  : req0_a;
        lat_b  <= grant1 ? req1_b  : req0_b;
        lat_op <= grant1 ? req1_op : req0_op;
        lat_id <= grant1;
        rr_ptr <= grant0;
      end
      if (state == ST_EXEC) begin
        rsp_x  <= alu_x;
        rsp_y  <= alu_y;
        rsp_id <= lat_id;
      end
      if (state == ST_RESP && rsp_ready) op_count <= op_count + 1'b1;
    end
  end

  alu4_core u_core (
    .a  (lat_a),
    .b  (lat_b),
    .op (lat_op),
    .x  (alu_x),
    .y  (alu_y)
  );

  // Grants are masked during reset so nothing is handed off on a reset edge.
  assign req0_ready = grant0 && !rst;
  assign req1_ready = grant1 && !rst;
  assign rsp_valid  = (state == ST_RESP);
  assign busy       = (state != ST_IDLE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_alu4_arbiter.sv
// Self-checking bench for alu4_arbiter: directed scenarios plus random traffic against a timeline model.
module tb_alu4_arbiter;
  import alu4_pkg::*;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [3:0]       req0_a, req0_b, req0_op;
  logic [3:0]       req1_a, req1_b, req1_op;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [3:0]       rsp_x, rsp_y;
  logic             busy;
  logic [CNT_W-1:0] op_count;
  state_t           dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  alu4_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_x(rsp_x), .rsp_y(rsp_y),
    .busy(busy), .op_count(op_count), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int         n_assert = 0;
  int         n_fail   = 0;
  logic [8:0] exp_q[$];
  bit         mdl_busy;
  int         mdl_age;
  bit         mdl_ptr;
  logic [7:0] mdl_cnt;
  bit         last_g0, last_g1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (int'(op))
      0:  r = (ia != 0) ? 1 : 0;
      1:  r = $countones(a) % 2;
      2:  r = (ia == 15) ? 1 : 0;
      3:  r = (ia == 0) ? 1 : 0;
      4:  r = 15 - ia;
      5:  r = (ib == 0) ? 1 : 0;
      6:  r = 15 - ib;
      7:  r = (ib == 15) ? 1 : 0;
      8:  r = int'(a & b);
      9:  r = int'(a | b);
      10: r = int'(a ^ b);
      11: r = (ia > ib) ? 1 : 0;
      12: r = (ia < ib) ? 1 : 0;
      13: r = (ia == ib) ? 1 : 0;
      14: r = ia + ib;
      default: r = (256 + ia - ib) % 256;
    endcase
    return 8'(r);
  endfunction

  // One clock cycle: entered at posedge+1 with inputs applied, checks at posedge+3.
  task automatic tick();
    bit g0, g1, exp_v, hs;
    #2;
    g0    = !mdl_busy && req0_valid && (!req1_valid || !mdl_ptr);
    g1    = !mdl_busy && req1_valid && !g0;
    exp_v = mdl_busy && mdl_age >= 2;
    chk("req0_ready", {15'b0, req0_ready}, {15'b0, g0});
    chk("req1_ready", {15'b0, req1_ready}, {15'b0, g1});
    chk("busy", {15'b0, busy}, {15'b0, mdl_busy});
    chk("rsp_valid", {15'b0, rsp_valid}, {15'b0, exp_v});
    chk("op_count", {8'b0, op_count}, {8'b0, mdl_cnt});
    if (exp_v && exp_q.size() > 0)
      chk("rsp_payload", {7'b0, rsp_id, rsp_y, rsp_x}, {7'b0, exp_q[0]});
    hs = exp_v && rsp_ready;
    if (hs) begin
      void'(exp_q.pop_front());
      mdl_cnt++;
      mdl_busy = 1'b0;
    end else if (mdl_busy) begin
      mdl_age++;
    end
    if (g0 || g1) begin
      mdl_busy = 1'b1;
      mdl_age  = 1;
      mdl_ptr  = g0;
      if (g0) exp_q.push_back({1'b0, ref_alu(req0_op, req0_a, req0_b)});
      else    exp_q.push_back({1'b1, ref_alu(req1_op, req1_a, req1_b)});
    end
    last_g0 = g0;
    last_g1 = g1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input bit id, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
  endtask

  task automatic clear_req(input bit id);
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic set_rand(input bit id);
    set_req(id, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
  endtask

  // Reset for one edge, then check reset values while rst is still high.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("rst_req0_ready", {15'b0, req0_ready}, 16'h0);
    chk("rst_req1_ready", {15'b0, req1_ready}, 16'h0);
    chk("rst_rsp_valid", {15'b0, rsp_valid}, 16'h0);
    chk("rst_rsp_data", {7'b0, rsp_id, rsp_y, rsp_x}, 16'h0);
    chk("rst_busy", {15'b0, busy}, 16'h0);
    chk("rst_op_count", {8'b0, op_count}, 16'h0);
    rst      = 1'b0;
    mdl_busy = 1'b0;
    mdl_age  = 0;
    mdl_ptr  = 1'b0;
    mdl_cnt  = 8'h00;
    exp_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [CNT_W-1:0] cnt_snap;
    bit seen_255;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 4'h0; req0_b = 4'h0; req0_op = 4'h0;
    req1_a = 4'h0; req1_b = 4'h0; req1_op = 4'h0;
    rsp_ready = 1'b0;

    do_reset();
    repeat (2) tick();

    // Single requester add: 9 + 8 = 0x11, valid two cycles after grant
    set_req(0, OP_ADD, 4'h9, 4'h8);
    rsp_ready = 1'b1;
    #1 chk("add_ready", {14'b0, req1_ready, req0_ready}, 16'h0001);
    tick();
    clear_req(0);
    tick();
    #1 chk("add_rsp", {6'b0, rsp_valid, rsp_id, rsp_y, rsp_x}, {6'b0, 1'b1, 1'b0, 8'h11});
    tick();

    // Contention from reset: req0 first, then req1; req0 re-requests so req1 wins the tie
    do_reset();
    set_req(0, OP_SUB, 4'h3, 4'h5);
    set_req(1, OP_AND, 4'hC, 4'hA);
    rsp_ready = 1'b1;
    #1 chk("tie1_ready", {14'b0, req1_ready, req0_ready}, 16'h0001);
    tick();
    set_req(0, OP_XOR, 4'h5, 4'h3);
    tick();
    #1 chk("sub_rsp", {7'b0, rsp_id, rsp_y, rsp_x}, {7'b0, 1'b0, 8'hFE});
    tick();
    #1 chk("tie2_ready", {14'b0, req1_ready, req0_ready}, 16'h0002);
    tick();
    clear_req(1);
    tick();
    #1 chk("and_rsp", {7'b0, rsp_id, rsp_y, rsp_x}, {7'b0, 1'b1, 8'h08});
    tick();
    tick();
    clear_req(0);
    tick();
    tick();

    // Consumer stall: response held for 5 cycles with req1 waiting
    set_req(0, OP_OR, 4'h6, 4'h3);
    rsp_ready = 1'b0;
    tick();
    clear_req(0);
    set_req(1, OP_NOT_B, 4'h0, 4'h5);
    tick();
    cnt_snap = op_count;
    repeat (5) begin
      #1 chk("stall_hold", {6'b0, rsp_valid, rsp_id, rsp_y, rsp_x}, {6'b0, 1'b1, 1'b0, 8'h07});
      chk("stall_count", {8'b0, op_count}, {8'b0, cnt_snap});
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    tick();
    clear_req(1);
    repeat (2) tick();

    // Reset while in EXEC aborts the operation
    set_req(0, OP_ADD, 4'hF, 4'hF);
    tick();
    clear_req(0);
    do_reset();
    repeat (4) tick();

    // Opcode sweep with two operand sets
    for (int op = 0; op < 16; op++) begin
      for (int s = 0; s < 2; s++) begin
        set_req(0, 4'(op), (s == 0) ? 4'h0 : 4'hF, (s == 0) ? 4'h0 : 4'h1);
        tick();
        clear_req(0);
        tick();
        if (op == 3 && s == 0) #1 chk("zero_a", {12'b0, rsp_x}, 16'h0001);
        if (op == 11 && s == 1) #1 chk("gt_f1", {12'b0, rsp_x}, 16'h0001);
        tick();
      end
    end

    // Random traffic with random consumer back-pressure
    for (int i = 0; i < 600; i++) begin
      if (!req0_valid && $urandom_range(0, 1) == 1) set_rand(0);
      if (!req1_valid && $urandom_range(0, 1) == 1) set_rand(1);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (last_g0) clear_req(0);
      if (last_g1) clear_req(1);
    end
    clear_req(0);
    clear_req(1);
    rsp_ready = 1'b1;
    repeat (4) tick();

    // 256 back-to-back operations: counter reaches 255 then wraps
    do_reset();
    set_rand(0);
    set_rand(1);
    rsp_ready = 1'b1;
    seen_255 = 1'b0;
    for (int i = 0; i < 1000 && !(seen_255 && mdl_cnt == 8'h00); i++) begin
      tick();
      if (last_g0) set_rand(0);
      if (last_g1) set_rand(1);
      if (!seen_255 && mdl_cnt == 8'hFF) begin
        seen_255 = 1'b1;
        chk("cnt_255", {8'b0, op_count}, 16'h00FF);
      end
    end
    chk("cnt_wrap_seen", {15'b0, seen_255 && mdl_cnt == 8'h00}, 16'h0001);
    #1 chk("cnt_wrap", {8'b0, op_count}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
